fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream drain stage for the 16-bit, 8-deep fifo. It pulls one word at a time through the FIFO read port (RD/DOUT/VALID) and serialises it onto a UART TX line as two 8N1 frames, low byte first. It sits between the fifo output and the board TX pin and paces FIFO reads to the line rate.

Parameters:
CLKS_PER_BIT, 16, CLK cycles per UART bit period (minimum 2).
DATA_W, 16, FIFO word width; fixed at 16, two bytes per word.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-low reset.
EN  in  1  start-enable; gates only the issue of new reads.
EMPTY  in  1  from fifo EMPTY.
VALID  in  1  from fifo VALID; DOUT is valid in this cycle.
UNDER  in  1  from fifo UNDER.
DIN  in  16  from fifo DOUT.
RD  out  1  to fifo RD; single-cycle pulse.
TXD  out  1  serial output; idle high.
BUSY  out  1  high from the RD cycle through the end of the high-byte stop bit.
ERR  out  1  sticky underflow flag; cleared only by reset.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE, TXD=1, RD=0, BUSY=0, ERR=0, counters 0, shift register 0. A frame in flight is lost and the line returns high at once.
- States: IDLE, WAIT, START, DATA, STOP.
- IDLE: if EN=1 and EMPTY=0, drive RD=1 for this cycle only, set BUSY=1, go to WAIT. Otherwise RD=0 and stay.
- WAIT (exactly one cycle, the cycle after RD):
  - VALID=1: latch DIN, byte_sel=0, go to START.
  - VALID=0 or UNDER=1: set ERR=1, BUSY=0, go to IDLE. No frame is sent.
- START: TXD=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits of the selected byte, LSB first, each held for CLKS_PER_BIT cycles. A 3-bit bit index moves to STOP after bit 7.
- STOP: TXD=1 for CLKS_PER_BIT cycles. Then:
  - byte_sel=0: set byte_sel=1, go to START (high byte follows back-to-back).
  - byte_sel=1: BUSY=0, go to IDLE.
- Latency: RD at cycle t, DIN sampled at t+1, TXD falls at t+2. A word occupies 20*CLKS_PER_BIT cycles of line time.
- Continuous drain: the minimum gap between words is 2 cycles of TXD=1 (the IDLE cycle plus the WAIT cycle).
- Baud counter counts 0..CLKS_PER_BIT-1, is reset on every state entry, and is $clog2(CLKS_PER_BIT) bits wide.
- EN falling mid-word: the current word completes; no further RD is issued.
- RD is never asserted while EMPTY=1, and never more than once per word.
- TXD is driven from a register (glitch-free).

Decomposition:
- Shared package/header: DATA_W=16, BYTES_PER_WORD=2, FRAME_BITS=10, state encodings.
- Natural sub-module: uart_baud_tick. Counter that emits a one-cycle tick every CLKS_PER_BIT cycles and has a synchronous restart input. The FSM and shifter stay in fifo_uart_tx.

Test Plan (CLKS_PER_BIT=4, fifo instantiated upstream):
1. Hold RST=0 for 2 cycles with EMPTY=0 -> TXD=1, RD=0, BUSY=0, ERR=0 throughout; no RD in the first cycle after release unless EN=1.
2. Write 16'h1234, EN=1 -> exactly one RD pulse; TXD falls 2 cycles later. Low-byte frame 0,0,0,1,0,1,1,0,0,1 (start, 0x34 LSB first, stop), then high-byte frame 0,0,1,0,0,1,0,0,0,1 (0x12). Each bit lasts 4 cycles, 80 cycles total. BUSY drops when the second stop bit ends.
3. Fill the fifo with 0..7, EN=1 -> 8 RD pulses spaced 82 cycles apart; byte sequence 00,00,01,00,...,07,00; 2-cycle idle gap between words; fifo EMPTY=1 at the end; ERR=0.
4. EN=0 with 3 words queued -> no RD and TXD=1 for 200 cycles. Raise EN -> transmission starts within 2 cycles. Drop EN during word 1 -> word 1 completes and words 2-3 remain in the fifo.
5. Stub the fifo so VALID=0 in the WAIT cycle -> ERR=1 (and it stays 1), TXD stays 1, state returns to IDLE, BUSY=0.
6. Assert RST=0 during DATA bit 3 of a frame -> TXD=1 in the same cycle. After release, the next queued word is sent cleanly starting from its start bit.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants and state encoding for the FIFO-to-UART drain stage.
package fifo_uart_tx_pkg;
  localparam int DATA_W         = 16;
  localparam int BYTES_PER_WORD = 2;
  localparam int FRAME_BITS     = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;
endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, held at zero while restart is high.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls 16-bit words from the fifo read port and sends each as two 8N1 frames, low byte first.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              EMPTY,
  input  logic              VALID,
  input  logic              UNDER,
  input  logic [DATA_W-1:0] DIN,
  output logic              RD,
  output logic              TXD,
  output logic              BUSY,
  output logic              ERR
);
  import fifo_uart_tx_pkg::*;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              byte_sel;
  logic              tick;
  logic              restart;

  // Counter sits at zero through IDLE/WAIT; elsewhere every transition lands on a tick, so it wraps to 0.
  assign restart = (state == S_IDLE) || (state == S_WAIT);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (CLK),
    .rst_n  (RST),
    .restart(restart),
    .tick   (tick)
  );

  // Read strobe is issued in the IDLE cycle itself so DOUT arrives in WAIT.
  assign RD   = RST && (state == S_IDLE) && EN && !EMPTY;
  assign BUSY = RD || (state != S_IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      TXD      <= 1'b1;
      ERR      <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (RD) state <= S_WAIT;
        end
        S_WAIT: begin
          if (VALID && !UNDER) begin
            shreg    <= DIN;
            byte_sel <= 1'b0;
            TXD      <= 1'b0;
            state    <= S_START;
          end else begin
            ERR   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_START: begin
          if (tick) begin
            TXD     <= shreg[0];
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          // Eight shifts per byte leave the high byte in the low lane for the second frame.
          if (tick) begin
            shreg <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              TXD   <= 1'b1;
              state <= S_STOP;
            end else begin
              TXD     <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              TXD      <= 1'b0;
              state    <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small behavioural fifo and a line receiver.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0;
  logic        EMPTY = 1'b1;
  logic        VALID = 1'b0;
  logic        UNDER = 1'b0;
  logic [15:0] DIN = '0;
  logic        RD, TXD, BUSY, ERR;

  always #5 CLK = ~CLK;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(16)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .EMPTY(EMPTY), .VALID(VALID), .UNDER(UNDER),
    .DIN(DIN), .RD(RD), .TXD(TXD), .BUSY(BUSY), .ERR(ERR)
  );

  // Behavioural fifo: registered DOUT/VALID one cycle after RD, registered EMPTY.
  logic [15:0] fq[$];
  logic        push_v = 1'b0;
  logic [15:0] push_d = '0;
  logic        stub_invalid = 1'b0;

  always @(posedge CLK) begin
    if (RD) begin
      if (fq.size() > 0) begin
        DIN   <= fq.pop_front();
        VALID <= !stub_invalid;
        UNDER <= 1'b0;
      end else begin
        VALID <= 1'b0;
        UNDER <= 1'b1;
      end
    end else begin
      VALID <= 1'b0;
      UNDER <= 1'b0;
    end
    if (push_v) fq.push_back(push_d);
    EMPTY <= (fq.size() == 0);
  end

  int   cyc = 0;
  int   rd_cnt = 0;
  int   rd_times[$];
  logic log_rd = 1'b0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RD) begin
      rd_cnt <= rd_cnt + 1;
      if (log_rd) rd_times.push_back(cyc);
    end
  end

  // Line receiver: samples each bit in the middle of its period.
  logic [7:0] rx_q[$];
  logic [7:0] rb;
  int         rx_stop_err = 0;
  logic       rx_en = 1'b0;

  initial begin
    forever begin
      @(negedge CLK);
      if (rx_en && TXD === 1'b0) begin
        repeat (CPB + CPB / 2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          rb[i] = TXD;
          repeat (CPB) @(negedge CLK);
        end
        if (TXD !== 1'b1) rx_stop_err++;
        rx_q.push_back(rb);
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    @(negedge CLK);
    push_d = w;
    push_v = 1'b1;
    @(negedge CLK);
    push_v = 1'b0;
  endtask

  task automatic wait_rd(input int lim, output bit found);
    found = 1'b0;
    #1;
    for (int n = 0; n <= lim; n++) begin
      if (RD === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge CLK);
      #1;
    end
  endtask

  // exp holds the 20 line bits of a word, first-sent bit in bit 19.
  task automatic check_word(input logic [19:0] exp, input string name, input int lim);
    bit          found;
    int          rd0;
    bit          steady;
    logic [19:0] got;
    wait_rd(lim, found);
    chk({name, " rd seen"}, 32'(found), 1);
    if (!found) return;
    rd0 = rd_cnt;
    @(negedge CLK); #1;
    chk({name, " wait txd"}, 32'(TXD), 1);
    chk({name, " wait busy"}, 32'(BUSY), 1);
    steady = 1'b1;
    got = '0;
    for (int k = 0; k < 20 * CPB; k++) begin
      @(negedge CLK); #1;
      if (k % CPB == 1) got[19 - k / CPB] = TXD;
      if (TXD !== exp[19 - k / CPB] || BUSY !== 1'b1) steady = 1'b0;
    end
    chk({name, " frame bits"}, 32'(got), 32'(exp));
    chk({name, " every cycle"}, 32'(steady), 1);
    @(negedge CLK); #1;
    chk({name, " busy after"}, 32'(BUSY), 0);
    chk({name, " idle txd"}, 32'(TXD), 1);
    chk({name, " one read"}, rd_cnt - rd0, 1);
  endtask

  typedef struct {
    logic [15:0] word;
    logic [19:0] bits;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int rd0;
    bit quiet;

    vecs[0] = '{16'hA55A, 20'b0010110101_0101001011};
    vecs[1] = '{16'h00FF, 20'b0111111111_0000000001};
    vecs[2] = '{16'h8001, 20'b0100000001_0000000011};
    vecs[3] = '{16'hFFFF, 20'b0111111111_0111111111};
    vecs[4] = '{16'h0000, 20'b0000000001_0000000001};

    // Reset held with a word queued
    push(16'h1234);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) EN = 1'b1;
      @(negedge CLK); #1;
      chk("reset txd", 32'(TXD), 1);
      chk("reset rd", 32'(RD), 0);
      chk("reset busy", 32'(BUSY), 0);
      chk("reset err", 32'(ERR), 0);
    end
    @(negedge CLK);
    EN  = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("release no rd", 32'(RD), 0);
      chk("release txd", 32'(TXD), 1);
      @(negedge CLK);
    end

    // Single word 0x1234
    EN = 1'b1;
    check_word(20'b0001011001_0010010001, "w1234", 4);

    for (int i = 0; i < 5; i++) begin
      push(vecs[i].word);
      check_word(vecs[i].bits, $sformatf("vec%0d", i), 6);
    end

    // Continuous drain of 0..7
    EN = 1'b0;
    rx_en = 1'b1;
    log_rd = 1'b1;
    for (int i = 0; i < 8; i++) push(16'(i));
    EN = 1'b1;
    wait_rd(4, found);
    chk("drain start", 32'(found), 1);
    repeat (8 * 82 + 10) @(negedge CLK);
    #1;
    chk("drain rd pulses", rd_times.size(), 8);
    for (int i = 1; i < rd_times.size(); i++)
      chk($sformatf("drain spacing %0d", i), rd_times[i] - rd_times[i-1], 82);
    chk("drain byte count", rx_q.size(), 16);
    for (int i = 0; i < rx_q.size() && i < 16; i++)
      chk($sformatf("drain byte %0d", i), 32'(rx_q[i]), (i % 2 == 0) ? i / 2 : 0);
    chk("drain stop bits", rx_stop_err, 0);
    chk("drain err", 32'(ERR), 0);
    chk("drain empty", 32'(EMPTY), 1);
    chk("drain busy", 32'(BUSY), 0);
    rx_en = 1'b0;
    log_rd = 1'b0;

    // EN gating
    EN = 1'b0;
    push(16'h00FF);
    push(16'h8001);
    push(16'hA55A);
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); #1;
      if (RD !== 1'b0 || TXD !== 1'b1 || BUSY !== 1'b0) quiet = 1'b0;
    end
    chk("en low quiet", 32'(quiet), 1);
    chk("en low fifo kept", fq.size(), 3);
    @(negedge CLK);
    rd0 = rd_cnt;
    EN = 1'b1;
    wait_rd(2, found);
    chk("en rise rd", 32'(found), 1);
    repeat (30) @(negedge CLK);
    EN = 1'b0;
    repeat (60) @(negedge CLK);
    #1;
    chk("en drop one read", rd_cnt - rd0, 1);
    chk("en drop fifo left", fq.size(), 2);
    chk("en drop busy", 32'(BUSY), 0);
    chk("en drop txd", 32'(TXD), 1);

    // Reset during data bit 3 of word 0x8001
    @(negedge CLK);
    EN = 1'b1;
    wait_rd(2, found);
    chk("mid rd", 32'(found), 1);
    repeat (19) @(negedge CLK);
    #1;
    chk("mid bit3 txd", 32'(TXD), 0);
    chk("mid busy", 32'(BUSY), 1);
    RST = 1'b0;
    #1;
    chk("async reset txd", 32'(TXD), 1);
    chk("async reset rd", 32'(RD), 0);
    chk("async reset busy", 32'(BUSY), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    check_word(20'b0010110101_0101001011, "after reset", 4);

    // VALID missing in WAIT
    EN = 1'b0;
    push(16'h5555);
    stub_invalid = 1'b1;
    EN = 1'b1;
    wait_rd(2, found);
    chk("err rd", 32'(found), 1);
    rd0 = rd_cnt;
    @(negedge CLK); #1;
    chk("err wait txd", 32'(TXD), 1);
    chk("err wait busy", 32'(BUSY), 1);
    @(negedge CLK); #1;
    chk("err set", 32'(ERR), 1);
    chk("err busy", 32'(BUSY), 0);
    chk("err txd", 32'(TXD), 1);
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); #1;
      if (TXD !== 1'b1 || ERR !== 1'b1 || BUSY !== 1'b0) quiet = 1'b0;
    end
    chk("err sticky idle", 32'(quiet), 1);
    chk("err single read", rd_cnt - rd0, 1);
    stub_invalid = 1'b0;

    // Reset clears ERR
    RST = 1'b0;
    @(negedge CLK); #1;
    chk("reset clears err", 32'(ERR), 0);
    RST = 1'b1;
    EN = 1'b0;
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
